// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for the pixel sensor array: erase, expose, ramp-ADC convert,
// then serial readout of every pixel over a valid/ready handshake.
module pixel_readout_ctrl #(
  parameter int NUM_PIXELS   = 4,
  parameter int SEL_W        = $clog2(NUM_PIXELS),
  parameter int ERASE_CYCLES = 5,
  parameter int CONV_CYCLES  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       expose_len,
  output logic             erase,
  output logic             expose,
  output logic             convert,
  output logic [7:0]       ramp_code,
  output logic [SEL_W-1:0] pix_sel,
  input  logic [7:0]       pix_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    RD_LOAD,
    RD_SEND
  } state_t;

  // The first ERASE cycle arms the array, so the counter runs 0..ERASE_CYCLES
  // while erase is driven for ERASE_CYCLES of them.
  localparam logic [15:0]      ERASE_LAST = 16'(ERASE_CYCLES);
  localparam logic [15:0]      CONV_LAST  = 16'(CONV_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PIXELS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  exp_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      exp_len    <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      ramp_code  <= '0;
      pix_sel    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        cnt       <= '0;
        erase     <= 1'b0;
        expose    <= 1'b0;
        convert   <= 1'b0;
        ramp_code <= '0;
        pix_sel   <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (start) begin
              state   <= ERASE;
              busy    <= 1'b1;
              cnt     <= '0;
              exp_len <= (expose_len == 8'd0) ? 8'd1 : expose_len;
            end
          end
          ERASE: begin
            if (cnt == ERASE_LAST) begin
              state  <= EXPOSE;
              erase  <= 1'b0;
              expose <= 1'b1;
              cnt    <= '0;
            end else begin
              erase <= 1'b1;
              cnt   <= cnt + 16'd1;
            end
          end
          EXPOSE: begin
            if (cnt == {8'd0, exp_len} - 16'd1) begin
              state     <= CONVERT;
              expose    <= 1'b0;
              convert   <= 1'b1;
              ramp_code <= '0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          CONVERT: begin
            if (cnt == CONV_LAST) begin
              state     <= RD_LOAD;
              convert   <= 1'b0;
              ramp_code <= '0;
              pix_sel   <= '0;
              cnt       <= '0;
            end else begin
              ramp_code <= ramp_code + 8'd1;
              cnt       <= cnt + 16'd1;
            end
          end
          RD_LOAD: begin
            out_data  <= pix_data;
            out_valid <= 1'b1;
            state     <= RD_SEND;
          end
          RD_SEND: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (pix_sel == SEL_LAST) begin
                // busy stays high through the frame_done cycle
                state      <= IDLE;
                pix_sel    <= '0;
                frame_done <= 1'b1;
              end else begin
                pix_sel <= pix_sel + 1'b1;
                state   <= RD_LOAD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Scenario bench for pixel_readout_ctrl: frame timing, stalls, aborts, resets
// and an 8-pixel / 256-step instance, with a pixel scoreboard queue.
module tb_pixel_readout_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, out_ready;
  logic [7:0] expose_len;
  logic       erase, expose, convert, out_valid, busy, frame_done;
  logic [7:0] ramp_code, out_data, pix_data;
  logic [1:0] pix_sel;
  logic [7:0] mem_a [4];
  assign pix_data = mem_a[pix_sel];

  logic       start_b, out_ready_b;
  logic [7:0] expose_len_b;
  logic       erase_b, expose_b, convert_b, out_valid_b, busy_b, frame_done_b;
  logic [7:0] ramp_code_b, out_data_b, pix_data_b;
  logic [2:0] pix_sel_b;
  logic [7:0] mem_b [8];
  assign pix_data_b = mem_b[pix_sel_b];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  pixel_readout_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .expose_len(expose_len), .erase(erase), .expose(expose),
    .convert(convert), .ramp_code(ramp_code), .pix_sel(pix_sel),
    .pix_data(pix_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  pixel_readout_ctrl #(.NUM_PIXELS(8), .CONV_CYCLES(256)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort),
    .expose_len(expose_len_b), .erase(erase_b), .expose(expose_b),
    .convert(convert_b), .ramp_code(ramp_code_b), .pix_sel(pix_sel_b),
    .pix_data(pix_data_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pixels(input logic [31:0] vals);
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = vals[8*i +: 8];
      exp_q.push_back(vals[8*i +: 8]);
    end
  endtask

  // Drives one frame on the 4-pixel DUT from its start edge (edge 0) and
  // measures it; pixel transfers are checked against the scoreboard queue.
  task automatic run_frame(input logic [7:0] exp_in, input int stall_pix,
                           input int stall_len, input int stop_edge,
                           input int start_pulse_edge, input bit start_hold,
                           input int exp_change_edge,
                           output int n_erase, output int n_expose,
                           output int n_convert, output int ramp_bad,
                           output int stall_bad, output int busy_bad,
                           output int n_xfer, output int done_edge);
    int conv_idx, stall_cnt;
    bit stalled, fin;
    logic v_prev, r_prev;
    logic [7:0] d_prev, exp_d;
    n_erase = 0; n_expose = 0; n_convert = 0; ramp_bad = 0;
    stall_bad = 0; busy_bad = 0; n_xfer = 0; done_edge = -1;
    conv_idx = 0; stall_cnt = 0; stalled = 0; fin = 0;
    start = 1'b1; expose_len = exp_in; out_ready = 1'b1;
    tick();
    if (!start_hold) start = 1'b0;
    if (busy !== 1'b1) busy_bad++;
    for (int e = 1; e <= 700 && !fin; e++) begin
      if (e == start_pulse_edge) start = 1'b1;
      else if (!start_hold) start = 1'b0;
      if (e == exp_change_edge) expose_len = 8'd50;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
      v_prev = out_valid; d_prev = out_data; r_prev = out_ready;
      tick();
      if (v_prev && r_prev) begin
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got pixel %02h, expected no transfer", d_prev);
        end else begin
          exp_d = exp_q.pop_front();
          if (d_prev !== exp_d) begin
            errors++;
            $display("FAIL scoreboard_pixel%0d: got %02h, expected %02h", n_xfer - 1, d_prev, exp_d);
          end
        end
      end else if (v_prev && !r_prev) begin
        if (out_valid !== 1'b1 || out_data !== d_prev) stall_bad++;
      end
      if (erase === 1'b1) n_erase++;
      if (expose === 1'b1) n_expose++;
      if (convert === 1'b1) begin
        if (ramp_code !== 8'(conv_idx)) ramp_bad++;
        conv_idx++;
        n_convert++;
      end else if (ramp_code !== 8'd0) begin
        ramp_bad++;
      end
      if (busy !== 1'b1) busy_bad++;
      if (frame_done === 1'b1) begin
        done_edge = e;
        fin = 1;
      end
      if (out_valid === 1'b1 && n_xfer == stall_pix && !stalled && stall_len > 0) begin
        stall_cnt = stall_len;
        stalled = 1;
      end
      if (e == stop_edge) fin = 1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] snap;
    logic [23:0] snap_b;
    reset = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1; expose_len = 8'd10;
    start_b = 1'b1; out_ready_b = 1'b1; expose_len_b = 8'd3;
    tick(); tick(); tick();
    snap = {erase, expose, convert, ramp_code, pix_sel, out_data, out_valid, busy, frame_done};
    snap_b = {erase_b, expose_b, convert_b, ramp_code_b, pix_sel_b[1:0], out_data_b,
              out_valid_b, busy_b, frame_done_b};
    checks++;
    if (snap !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %06h, expected 000000", snap);
    end
    checks++;
    if (snap_b !== 24'd0 || pix_sel_b[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %06h, expected 000000", snap_b);
    end
    reset = 1'b0; start = 1'b0; start_b = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    int ne, nx, nc, rb, sb, bb, nt, de;
    load_pixels(32'h44332211);
    run_frame(8'd10, -1, 0, -1, -1, 1'b0, -1, ne, nx, nc, rb, sb, bb, nt, de);
    checks++; if (ne != 5)   begin errors++; $display("FAIL frame_erase_cycles: got %0d, expected 5", ne); end
    checks++; if (nx != 10)  begin errors++; $display("FAIL frame_expose_cycles: got %0d, expected 10", nx); end
    checks++; if (nc != 255) begin errors++; $display("FAIL frame_convert_cycles: got %0d, expected 255", nc); end
    checks++; if (rb != 0)   begin errors++; $display("FAIL frame_ramp_sequence: got %0d bad cycles, expected 0", rb); end
    checks++; if (bb != 0)   begin errors++; $display("FAIL frame_busy: got %0d low cycles, expected 0", bb); end
    checks++; if (nt != 4)   begin errors++; $display("FAIL frame_transfers: got %0d, expected 4", nt); end
    checks++; if (de != 279) begin errors++; $display("FAIL frame_done_edge: got %0d, expected 279", de); end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse: got done=%b busy=%b, expected 0 0", frame_done, busy);
    end
  endtask

  task automatic test_stall();
    int ne, nx, nc, rb, sb, bb, nt, de;
    load_pixels(32'h44332211);
    run_frame(8'd10, 2, 7, -1, -1, 1'b0, -1, ne, nx, nc, rb, sb, bb, nt, de);
    checks++; if (sb != 0)   begin errors++; $display("FAIL stall_hold: got %0d bad stall cycles, expected 0", sb); end
    checks++; if (nt != 4)   begin errors++; $display("FAIL stall_transfers: got %0d, expected 4", nt); end
    checks++; if (de != 286) begin errors++; $display("FAIL stall_done_edge: got %0d, expected 286", de); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_scoreboard_left: got %0d, expected 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_expose_zero();
    int ne, nx, nc, rb, sb, bb, nt, de;
    load_pixels(32'h3CC35AA5);
    run_frame(8'd0, -1, 0, -1, -1, 1'b0, 3, ne, nx, nc, rb, sb, bb, nt, de);
    checks++; if (nx != 1)   begin errors++; $display("FAIL zero_expose_cycles: got %0d, expected 1", nx); end
    checks++; if (de != 270) begin errors++; $display("FAIL zero_done_edge: got %0d, expected 270", de); end
    checks++; if (nt != 4)   begin errors++; $display("FAIL zero_transfers: got %0d, expected 4", nt); end
    tick();
  endtask

  task automatic test_abort_convert();
    int ne, nx, nc, rb, sb, bb, nt, de, seen;
    logic [23:0] snap;
    run_frame(8'd10, -1, 0, 115, -1, 1'b0, -1, ne, nx, nc, rb, sb, bb, nt, de);
    checks++;
    if (nc != 100 || ramp_code !== 8'd99) begin
      errors++;
      $display("FAIL abort_conv_reach: got %0d cycles ramp=%0d, expected 100 cycles ramp=99", nc, ramp_code);
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    snap = {erase, expose, convert, ramp_code, pix_sel, out_data, out_valid, busy, frame_done};
    checks++;
    if (snap !== 24'd0) begin
      errors++;
      $display("FAIL abort_conv_outputs: got %06h, expected 000000", snap);
    end
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (frame_done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_conv_quiet: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_abort_rdsend();
    int ne, nx, nc, rb, sb, bb, nt, de, seen;
    mem_a[0] = 8'h5E; mem_a[1] = 8'h6F; mem_a[2] = 8'h70; mem_a[3] = 8'h81;
    run_frame(8'd10, -1, 0, 272, -1, 1'b0, -1, ne, nx, nc, rb, sb, bb, nt, de);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5E || nt != 0) begin
      errors++;
      $display("FAIL abort_rd_reach: got valid=%b data=%02h xfers=%0d, expected 1 5e 0", out_valid, out_data, nt);
    end
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_rd_outputs: got valid=%b data=%02h busy=%b done=%b, expected 0 00 0 0",
               out_valid, out_data, busy, frame_done);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid !== 1'b0 || frame_done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_rd_quiet: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_reset_midframe();
    int ne, nx, nc, rb, sb, bb, nt, de;
    logic [23:0] snap;
    mem_a[0] = 8'hAB; mem_a[1] = 8'hCD; mem_a[2] = 8'hEF; mem_a[3] = 8'h01;
    run_frame(8'd10, -1, 0, 272, -1, 1'b0, -1, ne, nx, nc, rb, sb, bb, nt, de);
    reset = 1'b1;
    tick();
    snap = {erase, expose, convert, ramp_code, pix_sel, out_data, out_valid, busy, frame_done};
    checks++;
    if (snap !== 24'd0) begin
      errors++;
      $display("FAIL reset_midframe_outputs: got %06h, expected 000000", snap);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    int ne, nx, nc, rb, sb, bb, nt, de, seen;
    load_pixels(32'h44332211);
    run_frame(8'd10, -1, 0, -1, 10, 1'b0, -1, ne, nx, nc, rb, sb, bb, nt, de);
    checks++; if (ne != 5)   begin errors++; $display("FAIL start_ign_erase: got %0d, expected 5", ne); end
    checks++; if (de != 279) begin errors++; $display("FAIL start_ign_done_edge: got %0d, expected 279", de); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (erase !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ign_no_requeue: got erase_cycles=%0d busy=%b, expected 0 0", seen, busy);
    end
  endtask

  task automatic test_back_to_back();
    int ne, nx, nc, rb, sb, bb, nt, de, first, done2, drop;
    load_pixels(32'h44332211);
    run_frame(8'd10, -1, 0, -1, -1, 1'b1, -1, ne, nx, nc, rb, sb, bb, nt, de);
    checks++; if (de != 279) begin errors++; $display("FAIL b2b_done1_edge: got %0d, expected 279", de); end
    first = -1; done2 = -1; drop = 0;
    for (int k = 1; k <= 400 && done2 < 0; k++) begin
      tick();
      if (busy !== 1'b1) drop++;
      if (erase === 1'b1 && first < 0) begin
        first = k;
        start = 1'b0;
      end
      if (frame_done === 1'b1) done2 = k;
    end
    start = 1'b0;
    checks++; if (first != 2)   begin errors++; $display("FAIL b2b_second_erase: got %0d, expected 2", first); end
    checks++; if (done2 != 280) begin errors++; $display("FAIL b2b_done2_gap: got %0d, expected 280", done2); end
    checks++; if (drop != 0)    begin errors++; $display("FAIL b2b_busy_drop: got %0d, expected 0", drop); end
    tick();
  endtask

  task automatic test_param_override();
    int done_e, nc, rb, nt, ramp_max, sel_max, conv_idx;
    bit fin;
    logic v_prev;
    logic [7:0] d_prev, exp_d;
    for (int i = 0; i < 8; i++) begin
      mem_b[i] = 8'(8'h90 + 8'(i * 7));
      exp_q.push_back(mem_b[i]);
    end
    done_e = -1; nc = 0; rb = 0; nt = 0; ramp_max = 0; sel_max = 0; conv_idx = 0; fin = 0;
    expose_len_b = 8'd3; out_ready_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int e = 1; e <= 700 && !fin; e++) begin
      v_prev = out_valid_b; d_prev = out_data_b;
      tick();
      if (v_prev) begin
        nt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b_scoreboard_extra: got pixel %02h, expected no transfer", d_prev);
        end else begin
          exp_d = exp_q.pop_front();
          if (d_prev !== exp_d) begin
            errors++;
            $display("FAIL b_scoreboard_pixel%0d: got %02h, expected %02h", nt - 1, d_prev, exp_d);
          end
        end
      end
      if (convert_b === 1'b1) begin
        if (ramp_code_b !== 8'(conv_idx)) rb++;
        if (int'(ramp_code_b) > ramp_max) ramp_max = int'(ramp_code_b);
        conv_idx++;
        nc++;
      end
      if (int'(pix_sel_b) > sel_max) sel_max = int'(pix_sel_b);
      if (frame_done_b === 1'b1) begin
        done_e = e;
        fin = 1;
      end
    end
    checks++; if (nc != 256)      begin errors++; $display("FAIL b_convert_cycles: got %0d, expected 256", nc); end
    checks++; if (ramp_max != 255) begin errors++; $display("FAIL b_ramp_max: got %0d, expected 255", ramp_max); end
    checks++; if (rb != 0)        begin errors++; $display("FAIL b_ramp_sequence: got %0d bad cycles, expected 0", rb); end
    checks++; if (sel_max != 7)   begin errors++; $display("FAIL b_pix_sel_max: got %0d, expected 7", sel_max); end
    checks++; if (nt != 8)        begin errors++; $display("FAIL b_transfers: got %0d, expected 8", nt); end
    checks++; if (done_e != 281)  begin errors++; $display("FAIL b_done_edge: got %0d, expected 281", done_e); end
    tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_expose_zero();
    test_abort_convert();
    test_abort_rdsend();
    test_reset_midframe();
    test_start_ignored();
    test_back_to_back();
    test_param_override();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending pixels, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
- Frame sequencer for the 2x2 pixel sensor array.
- Runs one frame per `start`: erase, expose, ramp-ADC convert, then serial readout.
- During readout it drives the 4-to-1 pixel select mux and streams the selected 8-bit pixel values downstream over a valid/ready handshake.
- Sits between the top-level camera control and the pixel array plus output mux.

Parameters:
- NUM_PIXELS, 4, pixels read per frame; legal values are 2, 4, 8, 16.
- SEL_W, $clog2(NUM_PIXELS), width of the mux select; derived, not overridden.
- ERASE_CYCLES, 5, cycles the `erase` output is held high.
- CONV_CYCLES, 255, cycles of ramp conversion; legal range 1..256.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous frame abort.
- expose_len  in  8  exposure length in cycles; latched on an accepted start.
- erase  out  1  pixel erase/reset control.
- expose  out  1  pixel integrate control.
- convert  out  1  pixel comparator/ramp enable.
- ramp_code  out  8  ADC ramp value broadcast to the pixel latches.
- pix_sel  out  SEL_W  select to the pixel output mux.
- pix_data  in  8  mux output, combinational from `pix_sel`.
- out_data  out  8  registered pixel value.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream accepts `out_data`.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (synchronous, active-high): state = IDLE. All outputs 0: `erase`, `expose`, `convert`, `ramp_code`, `pix_sel`, `out_data`, `out_valid`, `busy`, `frame_done`. The internal cycle counter and latched exposure length are also cleared. Reset overrides all other inputs, including when asserted mid-frame.
- States: IDLE, ERASE, EXPOSE, CONVERT, RD_LOAD, RD_SEND. Every control output is a registered Moore output of the state.
- IDLE:
  - `start`=1 at edge t: state becomes ERASE at t+1.
  - Latch `exp_len` = (`expose_len`==0 ? 1 : `expose_len`); clear the counter.
- ERASE:
  - `erase`=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE:
  - `expose`=1 for exactly `exp_len` cycles, then CONVERT.
  - A zero `expose_len` at start yields a 1-cycle exposure.
- CONVERT:
  - `convert`=1 for exactly CONV_CYCLES cycles.
  - `ramp_code` = 0 on the first CONVERT cycle and increments by 1 each cycle, reaching CONV_CYCLES-1 on the last cycle.
  - `ramp_code` returns to 0 on exit; there is no 8-bit wrap because CONV_CYCLES ≤ 256.
  - Next state: RD_LOAD with `pix_sel`=0.
- RD_LOAD (1 cycle):
  - `pix_sel` is stable; `out_data` <= `pix_data` at the end of the cycle.
  - Next state: RD_SEND.
- RD_SEND:
  - `out_valid`=1; `out_data` is held until the transfer completes.
  - Transfer occurs when `out_valid` && `out_ready` at an edge.
  - On transfer with `pix_sel` < NUM_PIXELS-1: `pix_sel`++, next state RD_LOAD (`out_valid` drops for one cycle).
  - On transfer with `pix_sel` == NUM_PIXELS-1: state becomes IDLE, `pix_sel` becomes 0, `frame_done`=1 for one cycle.
  - `out_ready` stuck low stalls indefinitely with no data loss.
- Readout latency:
  - First `out_valid` appears 1 cycle after CONVERT ends.
  - Minimum pixel period is 2 cycles, giving 2*NUM_PIXELS cycles of readout.
- Minimum frame length with `out_ready` tied high: 1 + ERASE_CYCLES + `exp_len` + CONV_CYCLES + 2*NUM_PIXELS cycles from the start edge to the `frame_done` edge.
- `start` outside IDLE is ignored; it is not queued.
- `start` in the same cycle as `frame_done` is ignored, since the state is not yet IDLE. A new frame may start from the following cycle.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE; all outputs return to reset values.
  - No `frame_done`; any pending `out_data` is discarded.
  - `abort` in IDLE has no effect.
  - `abort` has priority over `start` and over a simultaneous handshake.
- `busy` is 1 from the cycle after the accepted `start` until the cycle `frame_done` is asserted, inclusive.

Test Plan:
1. Defaults, `expose_len`=10, `out_ready`=1, pixels 0x11/0x22/0x33/0x44 on `pix_sel` 0..3:
   - `erase` high 5 cycles, `expose` high 10 cycles.
   - `convert` high 255 cycles with `ramp_code` 0..254.
   - `out_data` sequence 0x11, 0x22, 0x33, 0x44.
   - `frame_done` on cycle 279 after start.
2. Same as scenario 1 but `out_ready` low for 7 cycles on pixel 2:
   - `out_valid` held high with 0x33 stable throughout the stall.
   - No skipped or duplicated pixels.
   - `frame_done` delayed by 7 cycles.
3. `expose_len`=0:
   - `expose` high for exactly 1 cycle.
   - `expose_len` changed mid-frame does not alter the current frame.
4. Abort timing:
   - `abort` on CONVERT cycle 100: next cycle IDLE, `busy`=0, `ramp_code`=0, no `frame_done`.
   - `abort` during RD_SEND with `out_ready`=1: no transfer counted, IDLE next cycle.
5. Reset and start interactions:
   - `reset` asserted in RD_SEND: all outputs 0 next cycle.
   - `start` pulsed during EXPOSE is ignored.
   - `start` held high continuously launches back-to-back frames separated by exactly 1 IDLE cycle.
6. Parameter override NUM_PIXELS=8, CONV_CYCLES=256:
   - `ramp_code` reaches 255 with no wrap.
   - `pix_sel` counts 0..7; eight transfers occur, then `frame_done`.
